panel_draw_arbiter: RTL and testbench

- Command-level front end for the RGB LED panel controller's write/update interface.
- Two requesters (port 0: MicroBlaze GPIO path, port 1: hardware pattern engine) issue rectangle-fill or frame-commit commands.
- Round-robin arbitration between the ports; each granted command expands into paced per-pixel write strobes (new_data) or a frame-swap strobe (update_panel).
- Sits directly between the command sources and the panel controller's x_address/y_address/color/new_data/update_panel inputs.

---
 rtl/panel_draw_arbiter_if.sv | 24 ++
 rtl/panel_draw_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_panel_draw_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/panel_draw_arbiter_if.sv
// panel_draw_arbiter_if
//   Command channel from one draw requester into panel_draw_arbiter.
//   master : the requester (drives valid and the command fields, samples ready)
//   slave  : the arbiter   (samples valid and the fields, drives ready)
//   Fields:
//     valid      command present
//     ready      command accepted this cycle (single-cycle pulse)
//     op         0 = rectangle fill, 1 = commit frame
//     x0, x1     rectangle column bounds (either order)
//     y0, y1     rectangle row bounds (either order)
//     color      fill colour {R,G,B}
interface panel_draw_arbiter_if;
  logic       valid;
  logic       ready;
  logic       op;
  logic [4:0] x0;
  logic [4:0] x1;
  logic [3:0] y0;
  logic [3:0] y1;
  logic [2:0] color;

  modport master (output valid, op, x0, x1, y0, y1, color, input ready);
  modport slave  (input valid, op, x0, x1, y0, y1, color, output ready);
endinterface

// File: rtl/panel_draw_arbiter.sv
// panel_draw_arbiter
//   Command front end for the RGB LED panel controller. Two requesters issue
//   rectangle-fill or frame-commit commands; a round-robin arbiter accepts one
//   at a time, and each command is expanded into paced per-pixel new_data
//   strobes (raster order, x inner) or an update_panel frame-swap pulse.
//   Ports:
//     clk          system clock
//     reset        asynchronous active-low reset
//     s0, s1       command channels (slave side); s0 wins the first tie
//     x_address    pixel column to the panel
//     y_address    pixel row to the panel
//     color        pixel colour to the panel
//     new_data     pixel write strobe
//     update_panel frame swap request
//     busy         high whenever a command is in progress
//     grant        one-hot owner of the current command, 00 when idle
module panel_draw_arbiter #(
  parameter int unsigned PIXEL_GAP   = 1,
  parameter int unsigned COMMIT_HOLD = 2,
  parameter int unsigned COMMIT_GAP  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  panel_draw_arbiter_if.slave        s0,
  panel_draw_arbiter_if.slave        s1,
  output logic [4:0]                 x_address,
  output logic [3:0]                 y_address,
  output logic [2:0]                 color,
  output logic                       new_data,
  output logic                       update_panel,
  output logic                       busy,
  output logic [1:0]                 grant
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;
  localparam logic [2:0] ST_CGAP   = 3'd6;

  localparam logic [15:0] PIX_LAST  = (PIXEL_GAP == 0) ? 16'd0 : 16'(PIXEL_GAP - 1);
  localparam logic [15:0] HOLD_LAST = 16'(COMMIT_HOLD - 1);
  localparam logic [15:0] CGAP_LAST = 16'(COMMIT_GAP - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [4:0]  x_lo_q, x_lo_d, x_hi_q, x_hi_d;
  logic [3:0]  y_lo_q, y_lo_d, y_hi_q, y_hi_d;
  logic [2:0]  fill_q, fill_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        new_data_q, new_data_d;
  logic        update_q, update_d;
  logic [4:0]  x_q, x_d;
  logic [3:0]  y_q, y_d;
  logic [2:0]  color_q, color_d;

  logic        in_idle, pick0, pick1, accept;
  logic        cmd_op;
  logic [4:0]  cmd_x0, cmd_x1;
  logic [3:0]  cmd_y0, cmd_y1;
  logic [2:0]  cmd_color;
  logic        row_end, last_pixel, advance;

  // Ready is combinational so the fields can be captured in the accept cycle.
  // It is qualified by reset so every output reads 0 while reset is held.
  assign in_idle  = reset && (state_q == ST_IDLE);
  assign pick0    = s0.valid && (!s1.valid || last_grant_q);
  assign pick1    = s1.valid && !pick0;
  assign s0.ready = in_idle && pick0;
  assign s1.ready = in_idle && pick1;
  assign accept   = s0.ready || s1.ready;

  always_comb begin
    cmd_op    = pick1 ? s1.op    : s0.op;
    cmd_x0    = pick1 ? s1.x0    : s0.x0;
    cmd_x1    = pick1 ? s1.x1    : s0.x1;
    cmd_y0    = pick1 ? s1.y0    : s0.y0;
    cmd_y1    = pick1 ? s1.y1    : s0.y1;
    cmd_color = pick1 ? s1.color : s0.color;
  end

  // Equality against the hi bounds lets 31/15 finish without wrapping.
  assign row_end    = (x_q == x_hi_q);
  assign last_pixel = row_end && (y_q == y_hi_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    x_lo_d       = x_lo_q;
    x_hi_d       = x_hi_q;
    y_lo_d       = y_lo_q;
    y_hi_d       = y_hi_q;
    fill_d       = fill_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    new_data_d   = 1'b0;
    update_d     = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_LOAD;
          op_d         = cmd_op;
          x_lo_d       = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
          x_hi_d       = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
          y_lo_d       = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
          y_hi_d       = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
          fill_d       = cmd_color;
          last_grant_d = pick1;
          grant_d      = {pick1, pick0};
          busy_d       = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_d = '0;
        if (op_q) begin
          state_d  = ST_COMMIT;
          update_d = 1'b1;
        end else begin
          state_d    = ST_STROBE;
          new_data_d = 1'b1;
          x_d        = x_lo_q;
          y_d        = y_lo_q;
          color_d    = fill_q;
        end
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (PIXEL_GAP == 0) begin
          advance = 1'b1;
        end else begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == PIX_LAST) advance = 1'b1;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      ST_COMMIT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_CGAP;
          cnt_d   = '0;
        end else begin
          update_d = 1'b1;
          cnt_d    = cnt_q + 16'd1;
        end
      end
      ST_CGAP: begin
        if (cnt_q == CGAP_LAST) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
    endcase

    // Raster advance; address registers keep the last pixel when the fill ends.
    if (advance) begin
      if (last_pixel) begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end else begin
        state_d    = ST_STROBE;
        new_data_d = 1'b1;
        if (row_end) begin
          x_d = x_lo_q;
          y_d = y_q + 4'd1;
        end else begin
          x_d = x_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      x_lo_q       <= '0;
      x_hi_q       <= '0;
      y_lo_q       <= '0;
      y_hi_q       <= '0;
      fill_q       <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      new_data_q   <= 1'b0;
      update_q     <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      x_lo_q       <= x_lo_d;
      x_hi_q       <= x_hi_d;
      y_lo_q       <= y_lo_d;
      y_hi_q       <= y_hi_d;
      fill_q       <= fill_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      new_data_q   <= new_data_d;
      update_q     <= update_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
    end
  end

  assign x_address    = x_q;
  assign y_address    = y_q;
  assign color        = color_q;
  assign new_data     = new_data_q;
  assign update_panel = update_q;
  assign busy         = busy_q;
  assign grant        = grant_q;

endmodule

// File: tb/tb_panel_draw_arbiter.sv
// tb_panel_draw_arbiter
//   Directed bench for panel_draw_arbiter. A command-level model predicts the
//   outputs from the accept cycle of each command with plain arithmetic and is
//   compared every cycle; directed tests pin key cycles and pixels by hand.
module tb_panel_draw_arbiter;
  localparam int G  = 1;
  localparam int H  = 2;
  localparam int CG = 2;
  localparam int P  = G + 2;

  logic       clk;
  logic       reset;
  logic [4:0] x_address;
  logic [3:0] y_address;
  logic [2:0] color;
  logic       new_data, update_panel, busy;
  logic [1:0] grant;

  panel_draw_arbiter_if s0_if ();
  panel_draw_arbiter_if s1_if ();

  panel_draw_arbiter #(.PIXEL_GAP(G), .COMMIT_HOLD(H), .COMMIT_GAP(CG)) dut (
    .clk          (clk),
    .reset        (reset),
    .s0           (s0_if),
    .s1           (s1_if),
    .x_address    (x_address),
    .y_address    (y_address),
    .color        (color),
    .new_data     (new_data),
    .update_panel (update_panel),
    .busy         (busy),
    .grant        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Observation logs filled by the monitor
  logic [11:0] strobe_q[$];
  int          strobe_cyc_q[$];
  int          upd_cyc_q[$];
  int          acc_port_q[$];
  int          acc_cyc_q[$];
  int          busy_fall;
  bit          prev_busy;

  // Command-level model
  int cyc = 0;
  bit m_active, m_op, m_port, m_last_grant;
  int m_acc, m_end, m_xlo, m_xhi, m_ylo, m_yhi, m_col, m_n;
  int m_px, m_py, m_pc;
  int r, j, k, w;
  int ax0, ax1, ay0, ay1;
  bit p0, p1;
  logic [31:0] e_nd, e_up, e_busy, e_grant;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      m_active = 0; m_last_grant = 1; m_px = 0; m_py = 0; m_pc = 0; prev_busy = 0;
      check("rst_outputs", {15'd0, x_address, y_address, color, new_data, update_panel, busy, grant}, 0);
      check("rst_ready", {s0_if.ready, s1_if.ready}, 0);
    end else begin
      e_nd = 0; e_up = 0; e_busy = 0; e_grant = 0;
      if (m_active) begin
        r = cyc - m_acc;
        if (r >= m_end) m_active = 0;
        else begin
          e_busy  = 1;
          e_grant = m_port ? 2 : 1;
          if (r >= 2) begin
            if (m_op) e_up = ((r - 2) < H) ? 1 : 0;
            else begin
              j = r - 2; k = j / P; w = m_xhi - m_xlo + 1;
              m_px = m_xlo + k % w; m_py = m_ylo + k / w; m_pc = m_col;
              e_nd = (j % P == 0) ? 1 : 0;
            end
          end
        end
      end
      check("new_data", new_data, e_nd);
      check("update_panel", update_panel, e_up);
      check("busy", busy, e_busy);
      check("grant", grant, e_grant);
      check("x_address", x_address, m_px);
      check("y_address", y_address, m_py);
      check("color", color, m_pc);
      p0 = s0_if.valid && (!s1_if.valid || m_last_grant);
      p1 = s1_if.valid && !p0;
      check("s0_ready", s0_if.ready, !m_active && p0);
      check("s1_ready", s1_if.ready, !m_active && p1);
      if (!m_active && (p0 || p1)) begin
        m_active = 1; m_acc = cyc; m_port = p1; m_last_grant = p1;
        m_op  = p1 ? s1_if.op : s0_if.op;
        ax0   = p1 ? s1_if.x0 : s0_if.x0;  ax1 = p1 ? s1_if.x1 : s0_if.x1;
        ay0   = p1 ? s1_if.y0 : s0_if.y0;  ay1 = p1 ? s1_if.y1 : s0_if.y1;
        m_col = p1 ? s1_if.color : s0_if.color;
        m_xlo = (ax0 < ax1) ? ax0 : ax1;  m_xhi = (ax0 < ax1) ? ax1 : ax0;
        m_ylo = (ay0 < ay1) ? ay0 : ay1;  m_yhi = (ay0 < ay1) ? ay1 : ay0;
        m_n   = (m_xhi - m_xlo + 1) * (m_yhi - m_ylo + 1);
        m_end = m_op ? (2 + H + CG) : (2 + m_n * P);
      end
      if (new_data) begin
        strobe_q.push_back({x_address, y_address, color});
        strobe_cyc_q.push_back(cyc);
      end
      if (update_panel) upd_cyc_q.push_back(cyc);
      if (s0_if.ready) begin acc_port_q.push_back(0); acc_cyc_q.push_back(cyc); end
      if (s1_if.ready) begin acc_port_q.push_back(1); acc_cyc_q.push_back(cyc); end
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;
    end
  end

  task automatic clear_log();
    strobe_q.delete(); strobe_cyc_q.delete(); upd_cyc_q.delete();
    acc_port_q.delete(); acc_cyc_q.delete(); busy_fall = -1;
  endtask

  task automatic check_pix(input string name, input int idx,
                           input logic [4:0] x, input logic [3:0] y, input logic [2:0] c);
    check(name, (idx < strobe_q.size()) ? {20'd0, strobe_q[idx]} : 32'hffff_ffff, {20'd0, x, y, c});
  endtask

  function automatic int strobe_cyc(input int idx);
    return (idx < strobe_cyc_q.size()) ? strobe_cyc_q[idx] : -1;
  endfunction

  function automatic int acc_cyc(input int idx);
    return (idx < acc_cyc_q.size()) ? acc_cyc_q[idx] : -1;
  endfunction

  task automatic drive(input bit port, input bit v, input bit op, input logic [4:0] x0, x1,
                       input logic [3:0] y0, y1, input logic [2:0] c);
    if (port) begin
      s1_if.valid = v; s1_if.op = op; s1_if.x0 = x0; s1_if.x1 = x1;
      s1_if.y0 = y0; s1_if.y1 = y1; s1_if.color = c;
    end else begin
      s0_if.valid = v; s0_if.op = op; s0_if.x0 = x0; s0_if.x1 = x1;
      s0_if.y0 = y0; s0_if.y1 = y1; s0_if.color = c;
    end
  endtask

  task automatic issue(input bit port, input bit op, input logic [4:0] x0, x1,
                       input logic [3:0] y0, y1, input logic [2:0] c);
    int n = 0;
    @(posedge clk); #1;
    drive(port, 1, op, x0, x1, y0, y1, c);
    do begin @(negedge clk); n++; end
    while (!(port ? s1_if.ready : s0_if.ready) && n < 100);
    check(port ? "s1_accept" : "s0_accept", port ? s1_if.ready : s0_if.ready, 1);
    @(posedge clk); #1;
    if (port) s1_if.valid = 0; else s0_if.valid = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (busy && n < budget);
    check("idle_timeout", busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 reset = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1;
  endtask

  initial begin
    int n, a;
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    busy_fall = -1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    reset = 1;

    // Fill x 2..4, y 1, colour 101
    clear_log();
    issue(0, 0, 5'd2, 5'd4, 4'd1, 4'd1, 3'b101);
    wait_idle(100);
    a = acc_cyc(0);
    check("t1_accepts", acc_port_q.size(), 1);
    check("t1_strobes", strobe_q.size(), 3);
    check_pix("t1_pix0", 0, 2, 1, 3'b101);
    check_pix("t1_pix1", 1, 3, 1, 3'b101);
    check_pix("t1_pix2", 2, 4, 1, 3'b101);
    check("t1_strobe0_cyc", strobe_cyc(0) - a, 2);
    check("t1_strobe1_cyc", strobe_cyc(1) - a, 5);
    check("t1_strobe2_cyc", strobe_cyc(2) - a, 8);
    check("t1_busy_fall", busy_fall - a, 11);

    // Reversed bounds
    clear_log();
    issue(0, 0, 5'd4, 5'd2, 4'd3, 4'd2, 3'b011);
    wait_idle(100);
    check("t2_strobes", strobe_q.size(), 6);
    check_pix("t2_pix0", 0, 2, 2, 3'b011);
    check_pix("t2_pix1", 1, 3, 2, 3'b011);
    check_pix("t2_pix2", 2, 4, 2, 3'b011);
    check_pix("t2_pix3", 3, 2, 3, 3'b011);
    check_pix("t2_pix4", 4, 3, 3, 3'b011);
    check_pix("t2_pix5", 5, 4, 3, 3'b011);

    // Both ports continuously valid after reset: grants alternate, port 0 first
    pulse_reset();
    clear_log();
    @(posedge clk); #1;
    drive(0, 1, 0, 5'd1, 5'd1, 4'd1, 4'd1, 3'd1);
    drive(1, 1, 0, 5'd5, 5'd5, 4'd6, 4'd6, 3'd6);
    n = 0;
    while (acc_port_q.size() < 4 && n < 200) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    s0_if.valid = 0; s1_if.valid = 0;
    wait_idle(100);
    check("t3_accepts", acc_port_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("t3_order", (i < acc_port_q.size()) ? acc_port_q[i] : -1, i % 2);
    check_pix("t3_pix0", 0, 1, 1, 3'd1);
    check_pix("t3_pix1", 1, 5, 6, 3'd6);

    // Commit from port 1 while port 0 waits
    clear_log();
    issue(1, 1, 5'd0, 5'd0, 4'd0, 4'd0, 3'd0);
    issue(0, 0, 5'd9, 5'd9, 4'd9, 4'd9, 3'd4);
    wait_idle(100);
    a = acc_cyc(0);
    check("t4_accepts", acc_port_q.size(), 2);
    check("t4_s0_wait", acc_cyc(1) - a, 6);
    check("t4_upd_count", upd_cyc_q.size(), 2);
    check("t4_upd0", ((upd_cyc_q.size() > 0) ? upd_cyc_q[0] : -1) - a, 2);
    check("t4_upd1", ((upd_cyc_q.size() > 1) ? upd_cyc_q[1] : -1) - a, 3);
    check("t4_first_strobe", strobe_cyc(0) - a, 8);
    check_pix("t4_pix0", 0, 9, 9, 3'd4);

    // Full panel
    clear_log();
    issue(1, 0, 5'd0, 5'd31, 4'd0, 4'd15, 3'd7);
    wait_idle(2000);
    check("t5_strobes", strobe_q.size(), 512);
    check_pix("t5_first", 0, 0, 0, 3'd7);
    check_pix("t5_last", 511, 31, 15, 3'd7);
    check("t5_hold_x", x_address, 31);
    check("t5_hold_y", y_address, 15);

    // Reset during the 5th pixel of a 3x3 fill
    clear_log();
    issue(0, 0, 5'd1, 5'd3, 4'd2, 4'd4, 3'd5);
    n = 0;
    while (strobe_q.size() < 5 && n < 200) begin @(negedge clk); #1; n++; end
    check("t6_reached_pix5", strobe_q.size(), 5);
    reset = 0;
    #1;
    check("t6_async_clear", {15'd0, x_address, y_address, color, new_data, update_panel, busy, grant}, 0);
    @(negedge clk); #1;
    @(negedge clk); #1 reset = 1;
    clear_log();
    issue(0, 0, 5'd7, 5'd6, 4'd9, 4'd9, 3'd2);
    wait_idle(100);
    check("t6_strobes", strobe_q.size(), 2);
    check_pix("t6_pix0", 0, 6, 9, 3'd2);
    check_pix("t6_pix1", 1, 7, 9, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
